// File: rtl/svc_fb_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : svc_fb_rd_arb
//  Description : Two-port AXI read-channel arbiter. Merges two upstream AR
//                channels onto one downstream AR channel and routes the
//                shared R channel back using the MSB of the downstream ID.
//                Each port has an outstanding-burst counter; a port whose
//                counter has reached its maximum is not granted.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          : clock, asynchronous active-high reset
//    s_axi_ar*         : two upstream AR channels, port i in slice i
//    s_axi_r*          : upstream R channel; rvalid/rready per port,
//                        rid/rdata/rresp/rlast shared
//    m_axi_ar*         : registered downstream AR channel,
//                        arid = {port index, upstream arid}
//    m_axi_r*          : downstream R channel
//  Configuration
//    SVC_FB_RD_ARB_PRIO_EN : when defined, port 0 has fixed priority;
//                            otherwise the two ports are served round-robin.
// ============================================================================
module svc_fb_rd_arb #(
    parameter int AXI_ADDR_WIDTH    = 16,
    parameter int AXI_DATA_WIDTH    = 16,
    parameter int AXI_ID_WIDTH      = 4,
    parameter int OUTSTANDING_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    // upstream AR
    input  logic [1:0]                      s_axi_arvalid,
    input  logic [2*(AXI_ID_WIDTH-1)-1:0]   s_axi_arid,
    input  logic [2*AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [15:0]                     s_axi_arlen,
    input  logic [5:0]                      s_axi_arsize,
    input  logic [3:0]                      s_axi_arburst,
    output logic [1:0]                      s_axi_arready,
    // upstream R
    output logic [1:0]                      s_axi_rvalid,
    output logic [AXI_ID_WIDTH-2:0]         s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rlast,
    input  logic [1:0]                      s_axi_rready,
    // downstream AR
    output logic                            m_axi_arvalid,
    output logic [AXI_ID_WIDTH-1:0]         m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    input  logic                            m_axi_arready,
    // downstream R
    input  logic                            m_axi_rvalid,
    input  logic [AXI_ID_WIDTH-1:0]         m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    output logic                            m_axi_rready
);

    localparam int IW = AXI_ID_WIDTH - 1;
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int OW = OUTSTANDING_WIDTH;

    localparam logic [OW-1:0] c_cnt_max = '1;
    localparam logic [OW-1:0] c_cnt_one = OW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                    arvalid_q, arvalid_d;
    logic [AXI_ID_WIDTH-1:0] arid_q,    arid_d;
    logic [AW-1:0]           araddr_q,  araddr_d;
    logic [7:0]              arlen_q,   arlen_d;
    logic [2:0]              arsize_q,  arsize_d;
    logic [1:0]              arburst_q, arburst_d;
    logic [1:0][OW-1:0]      cnt_q,     cnt_d;
`ifndef SVC_FB_RD_ARB_PRIO_EN
    logic                    last_q,    last_d;
`endif

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic       w_ar_load;
    logic [1:0] w_eligible;
    logic       w_grant;
    logic       w_grant_sel;
    logic       w_r_port;
    logic       w_r_last_hs;
    logic [1:0] w_inc;
    logic [1:0] w_dec;

    // ------------------------------------------------------------------
    // AR arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // The output register can take a new request whenever it is empty
        // or is being drained this cycle, which gives 1 AR per cycle.
        w_ar_load = !arvalid_q || m_axi_arready;

        for (int i = 0; i < 2; i++) begin
            w_eligible[i] = s_axi_arvalid[i] && (cnt_q[i] != c_cnt_max);
        end

`ifdef SVC_FB_RD_ARB_PRIO_EN
        w_grant_sel = !w_eligible[0];
`else
        // On a tie, serve the port that was not granted last.
        w_grant_sel = (&w_eligible) ? ~last_q : w_eligible[1];
`endif

        // Ready is suppressed while reset is asserted even though the empty
        // output register would otherwise look loadable.
        w_grant = w_ar_load && (|w_eligible) && !rst;

        s_axi_arready = 2'b00;
        if (w_grant) begin
            s_axi_arready = w_grant_sel ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
`ifndef SVC_FB_RD_ARB_PRIO_EN
        last_d    = last_q;
`endif

        if (w_ar_load) begin
            arvalid_d = |w_eligible;
        end

        if (w_grant) begin
            if (w_grant_sel) begin
                arid_d    = {1'b1, s_axi_arid[2*IW-1:IW]};
                araddr_d  = s_axi_araddr[2*AW-1:AW];
                arlen_d   = s_axi_arlen[15:8];
                arsize_d  = s_axi_arsize[5:3];
                arburst_d = s_axi_arburst[3:2];
            end else begin
                arid_d    = {1'b0, s_axi_arid[IW-1:0]};
                araddr_d  = s_axi_araddr[AW-1:0];
                arlen_d   = s_axi_arlen[7:0];
                arsize_d  = s_axi_arsize[2:0];
                arburst_d = s_axi_arburst[1:0];
            end
`ifndef SVC_FB_RD_ARB_PRIO_EN
            last_d = w_grant_sel;
`endif
        end
    end

    // ------------------------------------------------------------------
    // R routing (purely combinational, steered by the ID MSB)
    // ------------------------------------------------------------------
    always_comb begin
        w_r_port     = m_axi_rid[AXI_ID_WIDTH-1];
        s_axi_rvalid = {m_axi_rvalid && w_r_port, m_axi_rvalid && !w_r_port};
        m_axi_rready = s_axi_rready[w_r_port];
        s_axi_rid    = m_axi_rid[IW-1:0];
        s_axi_rdata  = m_axi_rdata;
        s_axi_rresp  = m_axi_rresp;
        s_axi_rlast  = m_axi_rlast;
        w_r_last_hs  = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    end

    // ------------------------------------------------------------------
    // Outstanding-burst counters
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 2; i++) begin
            w_inc[i] = s_axi_arvalid[i] && s_axi_arready[i];
            w_dec[i] = w_r_last_hs && (w_r_port == 1'(i));
            if (w_inc[i] && !w_dec[i]) begin
                cnt_d[i] = cnt_q[i] + c_cnt_one;
            end else if (w_dec[i] && !w_inc[i] && (cnt_q[i] != '0)) begin
                // A stray rlast with nothing outstanding is ignored.
                cnt_d[i] = cnt_q[i] - c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            cnt_q     <= '0;
`ifndef SVC_FB_RD_ARB_PRIO_EN
            // Pointing at port 1 lets port 0 win the first tie.
            last_q    <= 1'b1;
`endif
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            cnt_q     <= cnt_d;
`ifndef SVC_FB_RD_ARB_PRIO_EN
            last_q    <= last_d;
`endif
        end
    end

    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = arsize_q;
    assign m_axi_arburst = arburst_q;

endmodule
`default_nettype wire

// File: tb/tb_svc_fb_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_svc_fb_rd_arb
//  Description : Self-checking bench for svc_fb_rd_arb (OUTSTANDING_WIDTH=2,
//                so each port may hold at most 3 bursts). A small reference
//                model predicts grants and pushes the expected downstream AR
//                payload into a queue; entries are popped and compared when
//                the downstream AR handshake happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_svc_fb_rd_arb;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int IDW  = 4;
    localparam int IW   = IDW - 1;
    localparam int OW   = 2;
    localparam int MAXC = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        s_axi_arvalid;
    logic [2*IW-1:0]   s_axi_arid;
    logic [2*AW-1:0]   s_axi_araddr;
    logic [15:0]       s_axi_arlen;
    logic [5:0]        s_axi_arsize;
    logic [3:0]        s_axi_arburst;
    logic [1:0]        s_axi_arready;
    logic [1:0]        s_axi_rvalid;
    logic [IW-1:0]     s_axi_rid;
    logic [DW-1:0]     s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic [1:0]        s_axi_rready;
    logic              m_axi_arvalid;
    logic [IDW-1:0]    m_axi_arid;
    logic [AW-1:0]     m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arready;
    logic              m_axi_rvalid;
    logic [IDW-1:0]    m_axi_rid;
    logic [DW-1:0]     m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rready;

    svc_fb_rd_arb #(
        .AXI_ADDR_WIDTH    (AW),
        .AXI_DATA_WIDTH    (DW),
        .AXI_ID_WIDTH      (IDW),
        .OUTSTANDING_WIDTH (OW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arready (s_axi_arready),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rready  (s_axi_rready),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          mcnt [2];
    logic        mlast;
    logic        mvalid;
    logic [32:0] sbq [$];   // {arid[3:0], addr[15:0], len[7:0], size[2:0], burst[1:0]}
    logic [1:0]  obs_rdy;
    logic [1:0]  seq [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant of step k in a both-ports-valid run that starts right
    // after reset with empty counters.
    function automatic logic [1:0] exp_seq(input int k);
`ifdef SVC_FB_RD_ARB_PRIO_EN
        return (k < MAXC) ? 2'b01 : 2'b10;
`else
        return (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
    endfunction

    task automatic set_ar(input logic [1:0] v);
        s_axi_arvalid = v;
        s_axi_arid    = 6'($urandom);
        s_axi_araddr  = 32'($urandom);
        s_axi_arlen   = 16'($urandom);
        s_axi_arsize  = 6'($urandom);
        s_axi_arburst = 4'($urandom);
    endtask

    task automatic r_set(input logic v, input logic [3:0] id, input logic last,
                         input logic [1:0] rdy);
        m_axi_rvalid = v;
        m_axi_rid    = id;
        m_axi_rlast  = last;
        m_axi_rdata  = 16'($urandom);
        m_axi_rresp  = 2'($urandom);
        s_axi_rready = rdy;
    endtask

    task automatic model_reset();
        mcnt[0] = 0;
        mcnt[1] = 0;
        mlast   = 1'b1;
        mvalid  = 1'b0;
        sbq.delete();
    endtask

    // One clock cycle: inputs already driven (just after a negedge).
    // Checks AR outputs against the model, then advances the model.
    task automatic cycle();
        logic [1:0]    elig;
        logic [1:0]    exp_rdy;
        logic          load;
        logic          psel;
        logic          rp;
        logic          inc;
        logic          dec;
        logic [32:0]   pl;
        logic [IW-1:0] aid;
        #1;
        load = !mvalid || m_axi_arready;
        for (int i = 0; i < 2; i++) elig[i] = s_axi_arvalid[i] && (mcnt[i] < MAXC);
`ifdef SVC_FB_RD_ARB_PRIO_EN
        psel = !elig[0];
`else
        psel = (elig == 2'b11) ? !mlast : elig[1];
`endif
        exp_rdy = (load && elig != 2'b00) ? (psel ? 2'b10 : 2'b01) : 2'b00;
        chk("s_arready", s_axi_arready, exp_rdy);
        chk("m_arvalid", m_axi_arvalid, mvalid);
        obs_rdy = s_axi_arready;

        if (mvalid && m_axi_arready) begin
            chk("sb_nonempty", (sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                pl = sbq.pop_front();
                chk("m_arid",    m_axi_arid,    pl[32:29]);
                chk("m_araddr",  m_axi_araddr,  pl[28:13]);
                chk("m_arlen",   m_axi_arlen,   pl[12:5]);
                chk("m_arsize",  m_axi_arsize,  pl[4:2]);
                chk("m_arburst", m_axi_arburst, pl[1:0]);
            end
        end

        rp = m_axi_rid[IDW-1];
        for (int i = 0; i < 2; i++) begin
            inc = (exp_rdy[i] == 1'b1);
            dec = m_axi_rvalid && s_axi_rready[rp] && m_axi_rlast && (rp == 1'(i));
            if (inc && !dec) mcnt[i]++;
            else if (dec && !inc && mcnt[i] > 0) mcnt[i]--;
        end

        if (exp_rdy != 2'b00) begin
            aid = psel ? s_axi_arid[5:3] : s_axi_arid[2:0];
            if (psel)
                sbq.push_back({1'b1, aid, s_axi_araddr[31:16], s_axi_arlen[15:8],
                               s_axi_arsize[5:3], s_axi_arburst[3:2]});
            else
                sbq.push_back({1'b0, aid, s_axi_araddr[15:0], s_axi_arlen[7:0],
                               s_axi_arsize[2:0], s_axi_arburst[1:0]});
            mlast = psel;
        end
        if (load) mvalid = (elig != 2'b00);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Flush the downstream AR register and retire every outstanding burst.
    task automatic drain();
        set_ar(2'b00);
        m_axi_arready = 1'b1;
        cycle();
        cycle();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8 && mcnt[p] > 0; k++) begin
                r_set(1'b1, {1'(p), 3'd0}, 1'b1, 2'b11);
                cycle();
            end
        end
        r_set(1'b0, 4'd0, 1'b0, 2'b00);
        cycle();
    endtask

    initial begin
        rst = 1'b0;
        set_ar(2'b00);
        m_axi_arready = 1'b0;
        r_set(1'b0, 4'd0, 1'b0, 2'b00);
        model_reset();

        // ---- Reset state ----
        #1 rst = 1'b1;
        set_ar(2'b11);
        m_axi_arready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_arready", s_axi_arready, 0);
        chk("rst_araddr",  m_axi_araddr,  0);
        chk("rst_arid",    m_axi_arid,    0);
        rst = 1'b0;
        model_reset();

        // ---- Both ports continuously valid, downstream always ready ----
        for (int k = 0; k < 6; k++) begin
            set_ar(2'b11);
            cycle();
            seq[k] = obs_rdy;
        end
        for (int k = 0; k < 6; k++) chk("grant_seq", seq[k], exp_seq(k));
        drain();

        // ---- Downstream stall: payload held, no upstream ready ----
        set_ar(2'b10);
        m_axi_arready = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            set_ar(2'b11);
            cycle();
            chk("stall_rdy", obs_rdy, 2'b00);
            chk("stall_addr", m_axi_araddr, sbq[0][28:13]);
            chk("stall_id",   m_axi_arid,   sbq[0][32:29]);
        end
        drain();

        // ---- Port 0 hits its outstanding limit ----
        m_axi_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_ar(2'b01);
            cycle();
            chk("lim0_grant", obs_rdy, (k < MAXC) ? 2'b01 : 2'b00);
        end
        r_set(1'b1, {1'b0, 3'd5}, 1'b1, 2'b01);
        cycle();
        chk("lim0_rlast_cycle", obs_rdy, 2'b00);
        r_set(1'b0, 4'd0, 1'b0, 2'b00);
        cycle();
        chk("lim0_regrant", obs_rdy, 2'b01);
        drain();

        // ---- R routing to port 1 and its counter release ----
        m_axi_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_ar(2'b10);
            cycle();
        end
        chk("lim1_stalled", obs_rdy, 2'b00);
        r_set(1'b1, 4'b1011, 1'b1, 2'b01);
        m_axi_rdata = 16'hBEEF;
        #1;
        chk("r_rvalid",  s_axi_rvalid, 2'b10);
        chk("r_mrready", m_axi_rready, 0);
        chk("r_rid",     s_axi_rid,    3);
        chk("r_rdata",   s_axi_rdata,  16'hBEEF);
        chk("r_rlast",   s_axi_rlast,  1);
        cycle();
        s_axi_rready = 2'b10;
        #1;
        chk("r_mrready_hs", m_axi_rready, 1);
        cycle();
        r_set(1'b0, 4'd0, 1'b0, 2'b00);
        cycle();
        chk("lim1_regrant", obs_rdy, 2'b10);
        drain();

        // ---- Reset mid-traffic with port 0 holding two bursts ----
        m_axi_arready = 1'b1;
        set_ar(2'b01);
        cycle();
        set_ar(2'b01);
        cycle();
        set_ar(2'b11);
        m_axi_arready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_arvalid", m_axi_arvalid, 0);
        chk("mrst_arready", s_axi_arready, 0);
        chk("mrst_araddr",  m_axi_araddr,  0);
        chk("mrst_arid",    m_axi_arid,    0);
        chk("mrst_arlen",   m_axi_arlen,   0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        m_axi_arready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_ar(2'b11);
            cycle();
            seq[k] = obs_rdy;
        end
        for (int k = 0; k < 6; k++) chk("post_rst_seq", seq[k], exp_seq(k));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
